// File: rtl/rf_pkg.sv
// rtl/rf_pkg.sv - register-file widths and the buffered mul/div result type
package rf_pkg;

  localparam int DATA_WIDTH   = 32;
  localparam int ADDR_WIDTH   = 5;
  localparam int REG_COUNT    = 32;
  localparam int STARVE_LIMIT = 4;

  // "reg" is a keyword, so the destination field is named dest
  typedef struct packed {
    logic [ADDR_WIDTH-1:0] dest;
    logic [DATA_WIDTH-1:0] data;
  } md_result_t;

endpackage

// File: rtl/result_fifo.sv
// rtl/result_fifo.sv - small synchronous FIFO holding mul/div results until a free write slot
module result_fifo
  import rf_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic                   push,
  input  md_result_t             push_data,
  input  logic                   pop,
  output md_result_t             head,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW-1:0] PTR_ONE = 1;
  localparam logic [PW:0]   CNT_ONE = 1;
  localparam logic [PW:0]   CNT_FULL = DEPTH[PW:0];

  md_result_t    mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  // Storage carries no reset; only the pointers and count define validity
  always_ff @(posedge CLK) begin
    if (push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  assign head  = mem[rd_ptr];
  assign full  = (count == CNT_FULL);
  assign empty = (count == '0);

endmodule

// File: rtl/reg_write_arbiter.sv
// rtl/reg_write_arbiter.sv - shares the register-file write port between WB and buffered mul/div results
module reg_write_arbiter #(
  parameter int DATA_WIDTH   = rf_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH   = rf_pkg::ADDR_WIDTH,
  parameter int FIFO_DEPTH   = 2,
  parameter int STARVE_LIMIT = rf_pkg::STARVE_LIMIT
) (
  input  logic                          CLK,
  input  logic                          RESET,
  input  logic                          WB_WRITEENABLE,
  input  logic [ADDR_WIDTH-1:0]         WB_WRITEREG,
  input  logic [DATA_WIDTH-1:0]         WB_WRITEDATA,
  output logic                          WB_STALL,
  input  logic                          MD_ISSUE,
  input  logic [ADDR_WIDTH-1:0]         MD_ISSUE_REG,
  input  logic                          MD_VALID,
  output logic                          MD_READY,
  input  logic [ADDR_WIDTH-1:0]         MD_WRITEREG,
  input  logic [DATA_WIDTH-1:0]         MD_WRITEDATA,
  input  logic [ADDR_WIDTH-1:0]         READREG1,
  input  logic [ADDR_WIDTH-1:0]         READREG2,
  output logic                          HAZARD,
  output logic [rf_pkg::REG_COUNT-1:0]  PENDING,
  output logic                          RF_WRITEENABLE,
  output logic [ADDR_WIDTH-1:0]         RF_WRITEREG,
  output logic [DATA_WIDTH-1:0]         RF_WRITEDATA
);

  import rf_pkg::*;

  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] CNT_ONE   = 1;
  localparam logic [CW-1:0] CNT_LIMIT = STARVE_LIMIT[CW-1:0];

  md_result_t                  fifo_push_data;
  md_result_t                  fifo_head;
  logic                        fifo_push;
  logic                        fifo_pop;
  logic                        fifo_full;
  logic                        fifo_empty;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;

  logic                        fifo_grant;
  logic                        wb_grant;
  logic                        starve_hit;
  logic [CW-1:0]               starve_cnt;

  logic [REG_COUNT-1:0]        pending;
  logic [REG_COUNT-1:0]        set_vec;
  logic [REG_COUNT-1:0]        clr_vec;
  logic                        hazard;
  logic                        issue_ok;

  assign fifo_push_data.dest = MD_WRITEREG;
  assign fifo_push_data.data = MD_WRITEDATA;
  assign fifo_push           = MD_VALID && MD_READY;
  assign fifo_pop            = fifo_grant;

  result_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_result_fifo (
    .CLK       (CLK),
    .RESET     (RESET),
    .push      (fifo_push),
    .push_data (fifo_push_data),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // No push-through: a full FIFO refuses even when its head drains this cycle
  assign MD_READY = !RESET && !fifo_full;

  // Forced drain wins over WB; otherwise WB first, then the FIFO fills idle slots
  assign starve_hit = (starve_cnt == CNT_LIMIT) && !fifo_empty;
  assign wb_grant   = WB_WRITEENABLE && !starve_hit;
  assign fifo_grant = !fifo_empty && (starve_hit || !WB_WRITEENABLE);
  assign WB_STALL   = starve_hit;

  assign RF_WRITEREG    = fifo_grant ? fifo_head.dest : WB_WRITEREG;
  assign RF_WRITEDATA   = fifo_grant ? fifo_head.data : WB_WRITEDATA;
  assign RF_WRITEENABLE = !RESET && (fifo_grant ? (fifo_head.dest != '0)
                                                : (wb_grant && (WB_WRITEREG != '0)));

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      starve_cnt <= '0;
    end else if ((fifo_count == '0) || fifo_grant) begin
      starve_cnt <= '0;
    end else if (starve_cnt != CNT_LIMIT) begin
      starve_cnt <= starve_cnt + CNT_ONE;
    end
  end

  assign hazard   = pending[READREG1] | pending[READREG2] | (MD_ISSUE & pending[MD_ISSUE_REG]);
  assign HAZARD   = hazard;
  assign issue_ok = MD_ISSUE && !hazard && (MD_ISSUE_REG != '0);

  always_comb begin
    set_vec = '0;
    clr_vec = '0;
    if (issue_ok) begin
      set_vec[MD_ISSUE_REG] = 1'b1;
    end
    if (fifo_grant) begin
      clr_vec[fifo_head.dest] = 1'b1;
    end
  end

  // Set is applied after clear so a new issue survives an older result's retire
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      pending <= '0;
    end else begin
      pending <= ((pending & ~clr_vec) | set_vec) & {{(REG_COUNT-1){1'b1}}, 1'b0};
    end
  end

  assign PENDING = pending;

endmodule

// File: tb/tb_reg_write_arbiter.sv
// tb/tb_reg_write_arbiter.sv - scoreboard bench for reg_write_arbiter
module tb_reg_write_arbiter;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        WB_WRITEENABLE;
  logic [4:0]  WB_WRITEREG;
  logic [31:0] WB_WRITEDATA;
  logic        WB_STALL;
  logic        MD_ISSUE;
  logic [4:0]  MD_ISSUE_REG;
  logic        MD_VALID;
  logic        MD_READY;
  logic [4:0]  MD_WRITEREG;
  logic [31:0] MD_WRITEDATA;
  logic [4:0]  READREG1;
  logic [4:0]  READREG2;
  logic        HAZARD;
  logic [31:0] PENDING;
  logic        RF_WRITEENABLE;
  logic [4:0]  RF_WRITEREG;
  logic [31:0] RF_WRITEDATA;

  typedef struct {
    logic [4:0]  r;
    logic [31:0] d;
  } wr_t;

  wr_t wb_q[$];
  wr_t md_q[$];
  wr_t mon_e;
  int  checks   = 0;
  int  failures = 0;
  int  wb_n     = 0;

  reg_write_arbiter dut (
    .CLK            (CLK),
    .RESET          (RESET),
    .WB_WRITEENABLE (WB_WRITEENABLE),
    .WB_WRITEREG    (WB_WRITEREG),
    .WB_WRITEDATA   (WB_WRITEDATA),
    .WB_STALL       (WB_STALL),
    .MD_ISSUE       (MD_ISSUE),
    .MD_ISSUE_REG   (MD_ISSUE_REG),
    .MD_VALID       (MD_VALID),
    .MD_READY       (MD_READY),
    .MD_WRITEREG    (MD_WRITEREG),
    .MD_WRITEDATA   (MD_WRITEDATA),
    .READREG1       (READREG1),
    .READREG2       (READREG2),
    .HAZARD         (HAZARD),
    .PENDING        (PENDING),
    .RF_WRITEENABLE (RF_WRITEENABLE),
    .RF_WRITEREG    (RF_WRITEREG),
    .RF_WRITEDATA   (RF_WRITEDATA)
  );

  always #5 CLK = ~CLK;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic wb_on();
    wr_t e;
    WB_WRITEENABLE = 1'b1;
    WB_WRITEREG    = 5'(1 + (wb_n % 20));
    WB_WRITEDATA   = 32'hB000_0000 + 32'(wb_n);
    e.r = WB_WRITEREG;
    e.d = WB_WRITEDATA;
    wb_q.push_back(e);
    wb_n++;
  endtask

  task automatic md_push(input logic [4:0] r, input logic [31:0] d, input bit expect_write);
    wr_t e;
    MD_VALID     = 1'b1;
    MD_WRITEREG  = r;
    MD_WRITEDATA = d;
    e.r = r;
    e.d = d;
    if (expect_write) md_q.push_back(e);
  endtask

  // WB data carries a 0xB top nibble, mul/div data never does
  always @(negedge CLK) begin
    if (RESET === 1'b0 && RF_WRITEENABLE === 1'b1) begin
      if (RF_WRITEDATA[31:28] == 4'hB) begin
        if (wb_q.size() == 0) begin
          check_eq("wb_extra_write", RF_WRITEENABLE, 0);
        end else begin
          mon_e = wb_q.pop_front();
          check_eq("wb_write_reg", RF_WRITEREG, mon_e.r);
          check_eq("wb_write_data", RF_WRITEDATA, mon_e.d);
        end
      end else begin
        if (md_q.size() == 0) begin
          check_eq("md_extra_write", RF_WRITEENABLE, 0);
        end else begin
          mon_e = md_q.pop_front();
          check_eq("md_write_reg", RF_WRITEREG, mon_e.r);
          check_eq("md_write_data", RF_WRITEDATA, mon_e.d);
        end
      end
    end
  end

  initial begin
    RESET = 1'b1;
    WB_WRITEENABLE = 1'b1;
    WB_WRITEREG = 5'd1;
    WB_WRITEDATA = 32'hB0FF_0000;
    MD_ISSUE = 1'b0;
    MD_ISSUE_REG = '0;
    MD_VALID = 1'b0;
    MD_WRITEREG = '0;
    MD_WRITEDATA = '0;
    READREG1 = '0;
    READREG2 = '0;

    repeat (2) @(posedge CLK);
    #1;
    check_eq("rst_rf_we", RF_WRITEENABLE, 0);
    check_eq("rst_md_ready", MD_READY, 0);
    check_eq("rst_wb_stall", WB_STALL, 0);
    check_eq("rst_hazard", HAZARD, 0);
    check_eq("rst_pending", PENDING, 0);
    WB_WRITEENABLE = 1'b0;
    RESET = 1'b0;
    #1;
    check_eq("idle_md_ready", MD_READY, 1);
    check_eq("idle_rf_we", RF_WRITEENABLE, 0);

    // issue R5, return its result with WB idle
    step(); MD_ISSUE = 1'b1; MD_ISSUE_REG = 5'd5; #1;
    check_eq("issue5_hazard", HAZARD, 0);
    step(); MD_ISSUE = 1'b0; READREG1 = 5'd5; md_push(5'd5, 32'h0000_0064, 1'b1); #1;
    check_eq("r5_pending", PENDING, 32'h0000_0020);
    check_eq("r5_hazard_pending", HAZARD, 1);
    check_eq("push_not_grantable", RF_WRITEENABLE, 0);
    check_eq("r5_md_ready", MD_READY, 1);
    step(); MD_VALID = 1'b0; #1;
    check_eq("r5_rf_we", RF_WRITEENABLE, 1);
    check_eq("r5_rf_reg", RF_WRITEREG, 5);
    check_eq("r5_hazard_before_clear", HAZARD, 1);
    step(); #1;
    check_eq("r5_pending_cleared", PENDING, 0);
    check_eq("r5_hazard_after_clear", HAZARD, 0);
    check_eq("r5_rf_idle", RF_WRITEENABLE, 0);
    READREG1 = '0;

    // queue R3/R4 under continuous WB traffic until the forced drain
    step(); wb_on(); md_push(5'd3, 32'd7, 1'b1);
    step(); wb_on(); md_push(5'd4, 32'd9, 1'b1);
    step(); wb_on(); MD_VALID = 1'b0; #1;
    check_eq("full_md_ready", MD_READY, 0);
    check_eq("denied_no_stall", WB_STALL, 0);
    step(); wb_on();
    step(); wb_on();
    step(); wb_on(); #1;
    check_eq("starve_wb_stall", WB_STALL, 1);
    check_eq("starve_rf_reg", RF_WRITEREG, 3);
    check_eq("starve_rf_data", RF_WRITEDATA, 7);
    step(); #1;
    check_eq("stall_one_cycle", WB_STALL, 0);
    check_eq("held_wb_data", RF_WRITEDATA, 32'hB000_0000 + 32'(wb_n - 1));
    step(); WB_WRITEENABLE = 1'b0; #1;
    check_eq("r4_drain_reg", RF_WRITEREG, 4);
    step(); #1;
    check_eq("drained_rf_we", RF_WRITEENABLE, 0);
    check_eq("drained_md_ready", MD_READY, 1);

    // issue while hazarded is ignored
    step(); MD_ISSUE = 1'b1; MD_ISSUE_REG = 5'd7;
    step(); #1;
    check_eq("r7_pending", PENDING, 32'h0000_0080);
    check_eq("reissue_r7_hazard", HAZARD, 1);
    step(); MD_ISSUE_REG = 5'd9; READREG1 = 5'd7; #1;
    check_eq("src_hazard", HAZARD, 1);
    step(); MD_ISSUE = 1'b0; READREG1 = '0; md_push(5'd0, 32'h55, 1'b0); #1;
    check_eq("hazard_no_set", PENDING, 32'h0000_0080);

    // R0 result is popped without a write
    step(); md_push(5'd7, 32'h77, 1'b1); #1;
    check_eq("r0_suppressed", RF_WRITEENABLE, 0);
    step(); MD_VALID = 1'b0; #1;
    check_eq("r0_popped_we", RF_WRITEENABLE, 1);
    check_eq("r0_popped_reg", RF_WRITEREG, 7);
    step(); #1;
    check_eq("r7_cleared", PENDING, 0);

    // issue R6 in the same cycle an unrelated older R6 result retires
    md_push(5'd6, 32'h66, 1'b1);
    step(); MD_VALID = 1'b0; MD_ISSUE = 1'b1; MD_ISSUE_REG = 5'd6; #1;
    check_eq("r6_old_write", RF_WRITEREG, 6);
    check_eq("r6_issue_hazard", HAZARD, 0);
    step(); MD_ISSUE = 1'b0; #1;
    check_eq("set_wins", PENDING, 32'h0000_0040);
    md_push(5'd6, 32'h6A, 1'b1);
    step(); MD_VALID = 1'b0;
    step(); #1;
    check_eq("r6_cleared", PENDING, 0);

    // reset with a full FIFO and a pending bit
    MD_ISSUE = 1'b1; MD_ISSUE_REG = 5'd3; wb_on();
    step(); MD_ISSUE = 1'b0; wb_on(); md_push(5'd3, 32'h33, 1'b0);
    step(); wb_on(); md_push(5'd4, 32'h44, 1'b0);
    step(); MD_VALID = 1'b0; WB_WRITEENABLE = 1'b0; #1;
    check_eq("pre_reset_pending", PENDING, 32'h0000_0008);
    check_eq("pre_reset_full", MD_READY, 0);
    RESET = 1'b1; #1;
    check_eq("async_rst_pending", PENDING, 0);
    check_eq("async_rst_rf_we", RF_WRITEENABLE, 0);
    check_eq("async_rst_md_ready", MD_READY, 0);
    step(); RESET = 1'b0; #1;
    check_eq("post_rst_rf_we", RF_WRITEENABLE, 0);
    check_eq("post_rst_md_ready", MD_READY, 1);
    step(); #1;
    check_eq("post_rst_idle", RF_WRITEENABLE, 0);

    step();
    check_eq("wb_q_drained", wb_q.size(), 0);
    check_eq("md_q_drained", md_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
